// File: rtl/prbs_pkg.sv
// Shared types and the Galois LFSR step used by the generator, the checker and the bench.
package prbs_pkg;

    typedef enum logic [1:0] {
        PRBS_IDLE   = 2'd0,
        PRBS_SEARCH = 2'd1,
        PRBS_LOCKED = 2'd2
    } prbs_state_e;

    // Widest word the shared step function handles; callers zero-extend narrower words.
    localparam int PRBS_MAX_W = 64;

    // One Galois step over the low w bits: shift right, fold bit 0 back through the taps.
    function automatic logic [PRBS_MAX_W-1:0] galois_step(
        input logic [PRBS_MAX_W-1:0] q,
        input logic [PRBS_MAX_W-1:0] poly,
        input int                    w
    );
        logic [PRBS_MAX_W-1:0] nxt;
        nxt = '0;
        for (int i = 0; i < PRBS_MAX_W - 1; i++) begin
            if (i < w - 1) begin
                nxt[i] = q[i+1] ^ (poly[i] & q[0]);
            end else if (i == w - 1) begin
                nxt[i] = q[0];
            end
        end
        if (w == PRBS_MAX_W) begin
            nxt[PRBS_MAX_W-1] = q[0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over an increment.
module prbs_sat_cnt #(
    parameter int WIDTH     = 16,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [WIDTH-1:0]     cnt
);

    localparam int SW = WIDTH + INC_WIDTH;

    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] sat;

    // The sum is wide enough that it can never wrap, so one compare decides the clamp.
    assign sum = SW'(cnt) + SW'(inc);
    assign sat = (sum > SW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

    // Count register: clear beats a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for a Galois LFSR word stream.
// Build option: define PRBS_CHECKER_BITERR_EN to count bit errors instead of word errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int                  DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] POLY        = '0,
    parameter int                  LOCK_CNT      = 4,
    parameter int                  LOSS_CNT      = 4,
    parameter int                  ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     vld_i,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    input  logic                     clr_i,
    output logic                     lock_o,
    output logic                     err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam int PW = $clog2(DATA_WIDTH + 1);

    prbs_state_e           state, state_nxt;
    logic [DATA_WIDTH-1:0] ref_word, ref_nxt;
    logic [DATA_WIDTH-1:0] exp_word;
    logic [MW-1:0]         match_cnt, match_nxt;
    logic [LW-1:0]         miss_cnt, miss_nxt;
    logic                  hit;
    logic                  err_event;
    logic [PW-1:0]         inc;

    // Word predicted from the reference; the zero word is the LFSR lock-up state and never seeds a match.
    assign exp_word = DATA_WIDTH'(galois_step(PRBS_MAX_W'(ref_word), PRBS_MAX_W'(POLY), DATA_WIDTH));
    assign hit      = (dat_i == exp_word);

    // Next-state logic: search re-seeds every beat, locked flywheels on the prediction.
    always_comb begin
        state_nxt = state;
        ref_nxt   = ref_word;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        err_event = 1'b0;
        if (vld_i) begin
            case (state)
                PRBS_IDLE: begin
                    ref_nxt   = dat_i;
                    match_nxt = '0;
                    state_nxt = PRBS_SEARCH;
                end
                PRBS_SEARCH: begin
                    ref_nxt = dat_i;
                    if (hit && (dat_i != '0)) begin
                        match_nxt = match_cnt + MW'(1);
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state_nxt = PRBS_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
                PRBS_LOCKED: begin
                    ref_nxt = exp_word;
                    if (hit) begin
                        miss_nxt = '0;
                    end else begin
                        err_event = 1'b1;
                        miss_nxt  = miss_cnt + LW'(1);
                        if (miss_cnt == LW'(LOSS_CNT - 1)) begin
                            state_nxt = PRBS_SEARCH;
                            match_nxt = '0;
                            ref_nxt   = dat_i;
                        end
                    end
                end
                default: begin
                    state_nxt = PRBS_IDLE;
                end
            endcase
        end
    end

    // State, reference and run-length registers plus the registered error pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= PRBS_IDLE;
            ref_word  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ref_word  <= ref_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err_o     <= err_event;
        end
    end

    assign lock_o = (state == PRBS_LOCKED);

`ifdef PRBS_CHECKER_BITERR_EN
    logic [DATA_WIDTH-1:0] diff;
    assign diff = dat_i ^ exp_word;

    // Bit-error weight of the current beat.
    always_comb begin
        inc = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            inc = inc + PW'(diff[i]);
        end
    end
`else
    assign inc = PW'(1);
`endif

    prbs_sat_cnt #(
        .WIDTH     (ERR_CNT_WIDTH),
        .INC_WIDTH (PW)
    ) u_err_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (clr_i),
        .en    (err_event),
        .inc   (inc),
        .cnt   (err_cnt_o)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker (W=8, POLY=8'hB8, 5-bit error counter so saturation is reachable).
// Honours PRBS_CHECKER_BITERR_EN the same way the design does.
module tb_prbs_checker;

    localparam int         W      = 8;
    localparam logic [7:0] POLY   = 8'hB8;
    localparam int         LOCKN  = 4;
    localparam int         LOSSN  = 4;
    localparam int         CW     = 5;
    localparam int         CMAX   = 31;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld   = 1'b0;
    logic [W-1:0]  dat   = '0;
    logic          clr   = 1'b0;
    logic          lock;
    logic          err;
    logic [CW-1:0] err_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [W-1:0] tx;

    // Reference model state, one field per observable rule.
    bit           m_started;
    bit           m_locked;
    logic [W-1:0] m_ref;
    int           m_run;
    int           m_miss;
    bit           m_err;
    int           m_cnt;

    prbs_checker #(
        .DATA_WIDTH    (W),
        .POLY          (POLY),
        .LOCK_CNT      (LOCKN),
        .LOSS_CNT      (LOSSN),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .vld_i     (vld),
        .dat_i     (dat),
        .clr_i     (clr),
        .lock_o    (lock),
        .err_o     (err),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    // Galois step as shift-and-xor: bit 0 falling off the end injects the tap mask.
    function automatic logic [W-1:0] model_step(input logic [W-1:0] q);
        logic [W-1:0] mask;
        mask = {1'b1, POLY[W-2:0]};
        return (q >> 1) ^ (q[0] ? mask : '0);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_locked  = 0;
        m_ref     = '0;
        m_run     = 0;
        m_miss    = 0;
        m_err     = 0;
        m_cnt     = 0;
    endtask

    task automatic model_beat(input bit v, input logic [W-1:0] d, input bit c);
        logic [W-1:0] e;
        bit           ev;
        int           inc;
        e  = model_step(m_ref);
        ev = 0;
`ifdef PRBS_CHECKER_BITERR_EN
        inc = $countones(d ^ e);
`else
        inc = 1;
`endif
        if (v) begin
            if (!m_started) begin
                m_started = 1;
                m_ref     = d;
                m_run     = 0;
            end else if (!m_locked) begin
                m_ref = d;
                if (d == e && d != 0) begin
                    m_run++;
                    if (m_run >= LOCKN) begin
                        m_locked = 1;
                        m_miss   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                m_ref = e;
                if (d == e) begin
                    m_miss = 0;
                end else begin
                    ev = 1;
                    m_miss++;
                    if (m_miss >= LOSSN) begin
                        m_locked = 0;
                        m_run    = 0;
                        m_ref    = d;
                    end
                end
            end
        end
        m_err = ev;
        if (c) m_cnt = 0;
        else if (ev) m_cnt = (m_cnt + inc > CMAX) ? CMAX : m_cnt + inc;
    endtask

    // Every cycle: advance the model on the edge, then compare all outputs just after it.
    initial begin : compare_proc
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_beat(vld, dat, clr);
            #1;
            checkOutput("lock_o", int'(lock), int'(m_locked));
            checkOutput("err_o", int'(err), int'(m_err));
            checkOutput("err_cnt_o", int'(err_cnt), m_cnt);
        end
    end

    task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic c);
        @(negedge clk);
        vld = v;
        dat = d;
        clr = c;
    endtask

    task automatic send_clean();
        applyStimulus(tx, 1'b1, 1'b0);
        tx = model_step(tx);
    endtask

    task automatic send_bad(input logic [W-1:0] flip, input logic c);
        applyStimulus(tx ^ flip, 1'b1, c);
        tx = model_step(tx);
    endtask

    task automatic idle_cycle();
        applyStimulus('0, 1'b0, 1'b0);
    endtask

    // Five clean beats (seed + LOCK_CNT matches) with optional random gaps, pinning lock timing.
    task automatic relock(input string tag, input bit gaps);
        for (int k = 1; k <= LOCKN + 1; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) idle_cycle();
            end
            send_clean();
            if (k == LOCKN + 1) checkOutput({tag, "_lock_before"}, int'(lock), 0);
        end
        idle_cycle();
        checkOutput({tag, "_lock_after"}, int'(lock), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld   = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : stim_proc
        checkOutput("step_01", int'(model_step(8'h01)), 8'hB8);
        checkOutput("step_17", int'(model_step(8'h17)), 8'hB3);
        checkOutput("step_B3", int'(model_step(8'hB3)), 8'hE1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_lock", int'(lock), 0);
        checkOutput("reset_cnt", int'(err_cnt), 0);

        $display("[TB] lock from seed 8'h01");
        tx = 8'h01;
        relock("t1", 1'b0);
        checkOutput("t1_cnt", int'(err_cnt), 0);

        $display("[TB] single corrupted word while locked");
        send_bad(8'h01, 1'b0);
        send_clean();
        checkOutput("t2_err_pulse", int'(err), 1);
        checkOutput("t2_cnt", int'(err_cnt), 1);
        send_clean();
        checkOutput("t2_err_clear", int'(err), 0);
        checkOutput("t2_lock", int'(lock), 1);

        $display("[TB] four lock-up words drop lock, then re-lock");
        for (int k = 0; k < LOSSN; k++) applyStimulus(8'h00, 1'b1, 1'b0);
        idle_cycle();
        checkOutput("t3_lock_lost", int'(lock), 0);
`ifndef PRBS_CHECKER_BITERR_EN
        checkOutput("t3_cnt", int'(err_cnt), 5);
`endif
        relock("t3", 1'b0);

        $display("[TB] counter saturation and clear priority");
        for (int g = 0; g < 12; g++) begin
            send_bad(8'h01, 1'b0);
            send_bad(8'h01, 1'b0);
            send_bad(8'h01, 1'b0);
            send_clean();
        end
        checkOutput("t4_sat", int'(err_cnt), CMAX);
        send_bad(8'h01, 1'b0);
        send_clean();
        checkOutput("t4_sat_hold", int'(err_cnt), CMAX);
        checkOutput("t4_err_pulse", int'(err), 1);
        send_bad(8'h01, 1'b1);
        send_clean();
        checkOutput("t4_clr_wins", int'(err_cnt), 0);
        checkOutput("t4_clr_err", int'(err), 1);
        checkOutput("t4_lock", int'(lock), 1);

        $display("[TB] gapped valid stream");
        pulse_reset();
        tx = 8'h5A;
        relock("t5", 1'b1);
        checkOutput("t5_cnt", int'(err_cnt), 0);

        $display("[TB] three flipped bits, then async reset mid-stream");
        send_bad(8'h07, 1'b0);
        send_clean();
        checkOutput("t6_err_pulse", int'(err), 1);
`ifdef PRBS_CHECKER_BITERR_EN
        checkOutput("t6_cnt", int'(err_cnt), 3);
`else
        checkOutput("t6_cnt", int'(err_cnt), 1);
`endif
        rst_n = 1'b0;
        vld   = 1'b0;
        #1;
        checkOutput("t6_rst_lock", int'(lock), 0);
        checkOutput("t6_rst_err", int'(err), 0);
        checkOutput("t6_rst_cnt", int'(err_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx = 8'hC8;
        relock("t6", 1'b0);

        repeat (3) idle_cycle();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
